// File: rtl/mem_arbiter.sv
// Shared single-port memory arbiter between instruction fetch and MEM stage.
// MEM has fixed priority; one transaction in flight; all outputs except stall_o registered.
// Optional macro ARB_TIMEOUT_EN adds an ack timeout that aborts the access and pulses err_o.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ack_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ack_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    input  logic              ram_ack_i,
    output logic              stall_o,
    output logic              err_o
);

    typedef enum logic [1:0] {IDLE, IF_ACC, MEM_ACC, DONE} state_t;

    state_t state_q, state_d;
    logic   grant_mem, grant_if, ack_hit, to_hit;
    logic   src_mem;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1) > 0 ? $clog2(TIMEOUT + 1) : 1;
    logic [CNT_W-1:0] cnt_q;
    logic             to_reached;
    assign to_reached = (32'(cnt_q) + 32'd1) >= TIMEOUT;
`else
    logic unused_cfg;
    assign unused_cfg = ^{32'(TIMEOUT)};
`endif

    // Pipeline freeze while any request has not yet been acknowledged
    assign stall_o = (mem_req_i & ~mem_ack_o) | (if_req_i & ~if_ack_o);

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode and transaction events
    always_comb begin
        state_d   = state_q;
        grant_mem = 1'b0;
        grant_if  = 1'b0;
        ack_hit   = 1'b0;
        to_hit    = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req_i) begin
                    state_d   = MEM_ACC;
                    grant_mem = 1'b1;
                end else if (if_req_i) begin
                    state_d  = IF_ACC;
                    grant_if = 1'b1;
                end
            end
            IF_ACC, MEM_ACC: begin
                if (ram_ack_i) begin
                    state_d = DONE;
                    ack_hit = 1'b1;
                end
`ifdef ARB_TIMEOUT_EN
                else if (to_reached) begin
                    state_d = DONE;
                    to_hit  = 1'b1;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    // Wait counter: cleared on grant, counts every access cycle
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)                                       cnt_q <= '0;
        else if (grant_mem || grant_if)                   cnt_q <= '0;
        else if (state_q == IF_ACC || state_q == MEM_ACC) cnt_q <= cnt_q + CNT_W'(1);
    end

    // Abort pulse alongside the forced ack
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) err_o <= 1'b0;
        else        err_o <= to_hit;
    end
`else
    assign err_o = 1'b0;
`endif

    // Command latch on grant, data capture and ack pulses on completion
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            src_mem     <= 1'b0;
            ram_en_o    <= 1'b0;
            ram_we_o    <= 1'b0;
            ram_addr_o  <= '0;
            ram_wdata_o <= '0;
            if_data_o   <= '0;
            mem_rdata_o <= '0;
            if_ack_o    <= 1'b0;
            mem_ack_o   <= 1'b0;
        end else begin
            if_ack_o  <= 1'b0;
            mem_ack_o <= 1'b0;
            if (grant_mem) begin
                src_mem     <= 1'b1;
                ram_en_o    <= 1'b1;
                ram_we_o    <= mem_we_i;
                ram_addr_o  <= mem_addr_i;
                ram_wdata_o <= mem_wdata_i;
            end else if (grant_if) begin
                src_mem    <= 1'b0;
                ram_en_o   <= 1'b1;
                ram_we_o   <= 1'b0;
                ram_addr_o <= if_addr_i;
            end
            if (ack_hit || to_hit) begin
                ram_en_o <= 1'b0;
                ram_we_o <= 1'b0;
                if (src_mem) begin
                    mem_ack_o <= 1'b1;
                    // ram_we_o still holds the latched write enable here
                    if (!ram_we_o) mem_rdata_o <= ack_hit ? ram_rdata_i : '0;
                end else begin
                    if_ack_o  <= 1'b1;
                    if_data_o <= ack_hit ? ram_rdata_i : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; honours ARB_TIMEOUT_EN (TIMEOUT=8 when defined).
module tb_mem_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 8;
`else
    localparam int unsigned TB_TIMEOUT = 255;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic [31:0] if_data_o;
    logic        if_ack_o;
    logic        mem_req_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic [31:0] mem_rdata_o;
    logic        mem_ack_o;
    logic        ram_en_o;
    logic        ram_we_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i = '0;
    logic        ram_ack_i = 1'b0;
    logic        stall_o;
    logic        err_o;

    int n_vec  = 0;
    int n_miss = 0;
    int waited;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o),
        .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i), .ram_ack_i(ram_ack_i),
        .stall_o(stall_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample 2ns after the rising edge
    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    initial begin
        // Reset state
        #3;
        check("rst_en", 32'(ram_en_o), 32'd0);
        check("rst_we", 32'(ram_we_o), 32'd0);
        check("rst_acks", {30'd0, if_ack_o, mem_ack_o}, 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_addr", ram_addr_o, 32'd0);
        check("rst_ifdata", if_data_o, 32'd0);
        tick();
        rst_i = 1'b1;
        tick();

        // IF-only fetch, ack after 3 access cycles
        if_req_i = 1'b1; if_addr_i = 32'h100;
        #1 check("if_stall_req", 32'(stall_o), 32'd1);
        tick();
        check("if_en", 32'(ram_en_o), 32'd1);
        check("if_addr", ram_addr_o, 32'h100);
        check("if_we", 32'(ram_we_o), 32'd0);
        tick();
        tick();
        check("if_wait_ack", 32'(if_ack_o), 32'd0);
        check("if_wait_stall", 32'(stall_o), 32'd1);
        ram_ack_i = 1'b1; ram_rdata_i = 32'hDEADBEEF;
        tick();
        check("if_ack", 32'(if_ack_o), 32'd1);
        check("if_data", if_data_o, 32'hDEADBEEF);
        check("if_en_done", 32'(ram_en_o), 32'd0);
        if_req_i = 1'b0; ram_ack_i = 1'b0;
        #1 check("if_stall_after", 32'(stall_o), 32'd0);
        tick();
        check("if_ack_pulse", 32'(if_ack_o), 32'd0);

        // Stray ram_ack_i in IDLE is ignored
        ram_ack_i = 1'b1; ram_rdata_i = 32'h0BADBAD0;
        tick();
        check("idle_ack_en", 32'(ram_en_o), 32'd0);
        check("idle_ack_acks", {30'd0, if_ack_o, mem_ack_o}, 32'd0);
        check("idle_ack_data", if_data_o, 32'hDEADBEEF);
        ram_ack_i = 1'b0;

        // Simultaneous requests: MEM load first, then IF
        if_req_i = 1'b1; if_addr_i = 32'h200;
        mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h40;
        tick();
        check("pri_addr_mem", ram_addr_o, 32'h40);
        check("pri_en_mem", 32'(ram_en_o), 32'd1);
        ram_ack_i = 1'b1; ram_rdata_i = 32'h11112222;
        tick();
        check("pri_mem_ack", {30'd0, if_ack_o, mem_ack_o}, 32'd1);
        check("pri_mem_data", mem_rdata_o, 32'h11112222);
        mem_req_i = 1'b0; ram_ack_i = 1'b0;
        tick();
        check("pri_idle_en", 32'(ram_en_o), 32'd0);
        tick();
        check("pri_addr_if", ram_addr_o, 32'h200);
        check("pri_en_if", 32'(ram_en_o), 32'd1);
        ram_ack_i = 1'b1; ram_rdata_i = 32'h33334444;
        tick();
        check("pri_if_ack", {30'd0, if_ack_o, mem_ack_o}, 32'd2);
        check("pri_if_data", if_data_o, 32'h33334444);
        if_req_i = 1'b0; ram_ack_i = 1'b0;
        tick();

        // MEM write leaves load data untouched
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h80; mem_wdata_i = 32'h55AA55AA;
        ram_rdata_i = 32'hFFFFFFFF;
        tick();
        check("wr_we", 32'(ram_we_o), 32'd1);
        check("wr_wdata", ram_wdata_o, 32'h55AA55AA);
        check("wr_addr", ram_addr_o, 32'h80);
        ram_ack_i = 1'b1;
        tick();
        check("wr_ack", 32'(mem_ack_o), 32'd1);
        check("wr_rdata_kept", mem_rdata_o, 32'h11112222);
        check("wr_we_done", 32'(ram_we_o), 32'd0);
        mem_req_i = 1'b0; mem_we_i = 1'b0; ram_ack_i = 1'b0;
        tick();

        // Reset during MEM_ACC aborts without ack
        mem_req_i = 1'b1; mem_addr_i = 32'hC0;
        tick();
        check("rm_en_before", 32'(ram_en_o), 32'd1);
        rst_i = 1'b0;
        #1 check("rm_en_async", 32'(ram_en_o), 32'd0);
        check("rm_rdata_clr", mem_rdata_o, 32'd0);
        ram_ack_i = 1'b1; ram_rdata_i = 32'h99999999;
        tick();
        check("rm_no_ack", 32'(mem_ack_o), 32'd0);
        ram_ack_i = 1'b0; mem_addr_i = 32'hC4;
        rst_i = 1'b1;
        tick();
        check("rm_fresh_en", 32'(ram_en_o), 32'd1);
        check("rm_fresh_addr", ram_addr_o, 32'hC4);
        ram_ack_i = 1'b1; ram_rdata_i = 32'hCAFEF00D;
        tick();
        check("rm_fresh_ack", 32'(mem_ack_o), 32'd1);
        check("rm_fresh_data", mem_rdata_o, 32'hCAFEF00D);

        // Back-to-back MEM requests: DONE gap, then one fresh grant
        ram_ack_i = 1'b0; mem_addr_i = 32'h14;
        tick();
        check("b2b_gap_en", 32'(ram_en_o), 32'd0);
        check("b2b_gap_ack", 32'(mem_ack_o), 32'd0);
        tick();
        check("b2b_en2", 32'(ram_en_o), 32'd1);
        check("b2b_addr2", ram_addr_o, 32'h14);
        ram_ack_i = 1'b1; ram_rdata_i = 32'h00000002;
        tick();
        check("b2b_ack2", 32'(mem_ack_o), 32'd1);
        check("b2b_data2", mem_rdata_o, 32'h00000002);
        mem_req_i = 1'b0; ram_ack_i = 1'b0;
        tick();
        tick();
        check("b2b_no_dup", 32'(ram_en_o), 32'd0);

        // No memory response at all
        mem_req_i = 1'b1; mem_addr_i = 32'h20; ram_rdata_i = 32'h12345678;
        tick();
        check("to_en", 32'(ram_en_o), 32'd1);
        waited = 0;
`ifdef ARB_TIMEOUT_EN
        while (!mem_ack_o && waited < 20) begin
            tick();
            waited++;
        end
        check("to_cycles", 32'(waited), 32'd8);
        check("to_err", 32'(err_o), 32'd1);
        check("to_ack", 32'(mem_ack_o), 32'd1);
        check("to_rdata", mem_rdata_o, 32'd0);
        mem_req_i = 1'b0;
        tick();
        check("to_err_pulse", 32'(err_o), 32'd0);
`else
        for (int i = 0; i < 100; i++) begin
            tick();
            if (mem_ack_o) waited++;
        end
        check("nto_no_ack", 32'(waited), 32'd0);
        check("nto_still_en", 32'(ram_en_o), 32'd1);
        check("nto_stall", 32'(stall_o), 32'd1);
        check("nto_err", 32'(err_o), 32'd0);
        mem_req_i = 1'b0;
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
`endif
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, address width.
REQ-002 Parameter: DATA_W, default 32, data width.
REQ-003 Parameter: TIMEOUT, default 255, max cycles waiting for ram_ack_i (used only with ARB_TIMEOUT_EN).
REQ-004 clk_i  in  1  single clock, all state updates on rising edge.
REQ-005 rst_i  in  1  reset, asynchronous, active-low.
REQ-006 if_req_i  in  1, if_addr_i  in  ADDR_W: instruction fetch request and address, held until if_ack_o.
REQ-007 if_data_o  out  DATA_W, if_ack_o  out  1: fetched word and one-cycle completion pulse.
REQ-008 mem_req_i  in  1, mem_we_i  in  1, mem_addr_i  in  ADDR_W, mem_wdata_i  in  DATA_W: MEM-stage access, held until mem_ack_o.
REQ-009 mem_rdata_o  out  DATA_W, mem_ack_o  out  1: load data and one-cycle completion pulse.
REQ-010 ram_en_o  out  1, ram_we_o  out  1, ram_addr_o  out  ADDR_W, ram_wdata_o  out  DATA_W: shared single-port memory command.
REQ-011 ram_rdata_i  in  DATA_W, ram_ack_i  in  1: memory read data and completion, variable latency >= 1 cycle.
REQ-012 stall_o  out  1: freezes all pipeline registers (IF_ID through MEM_WB) while any request is outstanding.
REQ-013 err_o  out  1: one-cycle pulse on aborted transaction.

Function
REQ-014 FSM states: IDLE, IF_ACC, MEM_ACC, DONE; registered state.
REQ-015 IDLE: mem_req_i -> MEM_ACC; else if_req_i -> IF_ACC; else stay; both high -> MEM_ACC (MEM fixed priority).
REQ-016 On grant, address/we/wdata latched into registers; ram_* outputs driven from latched copy, not live inputs.
REQ-017 ram_en_o = 1 exactly in IF_ACC and MEM_ACC; ram_we_o = latched mem_we_i in MEM_ACC, 0 otherwise.
REQ-018 IF_ACC/MEM_ACC: ram_ack_i sampled high -> DONE; ram_rdata_i captured into if_data_o (IF) or mem_rdata_o (MEM read) at that edge.
REQ-019 MEM write: mem_rdata_o unchanged.
REQ-020 DONE: lasts exactly one cycle; corresponding ack_o high; then IDLE; requests ignored in DONE.
REQ-021 Latency: req seen at edge N -> ram_en_o from N+1; ack sampled at edge M -> ack_o high cycle M..M+1; min req-to-ack 2 cycles.
REQ-022 if_data_o / mem_rdata_o hold last captured value until next capture.
REQ-023 stall_o = (mem_req_i & ~mem_ack_o) | (if_req_i & ~if_ack_o), combinational.
REQ-024 ram_ack_i in IDLE or DONE ignored.
REQ-025 Request dropped before ack: protocol violation; transaction still completes and acks.

Reset
REQ-026 rst_i low -> immediately: state IDLE, ram_en_o 0, ram_we_o 0, all acks 0, err_o 0, data/address registers 0, timeout counter 0.
REQ-027 Reset mid-transaction aborts it with no ack; pending memory response ignored.

Configuration
REQ-028 Macro ARB_TIMEOUT_EN defined: counter clears on grant, increments each ACC cycle; reaching TIMEOUT without ram_ack_i -> DONE, ack pulsed, captured data 0, err_o pulsed concurrently.
REQ-029 ARB_TIMEOUT_EN undefined: no counter, waits indefinitely; err_o tied 0, port retained.

Verification
REQ-030 IF only, addr 0x100, ram_ack_i after 3 cycles with 0xDEADBEEF -> if_ack_o one pulse, if_data_o 0xDEADBEEF, stall_o low after ack.
REQ-031 if_req_i and mem_req_i (load 0x40) same cycle -> MEM served first, then IF; ram_addr_o 0x40 then IF address; two ack pulses in order.
REQ-032 MEM write 0x55AA55AA to 0x80 -> ram_we_o 1, ram_wdata_o 0x55AA55AA; mem_rdata_o unchanged.
REQ-033 rst_i low during MEM_ACC -> ram_en_o 0 same cycle, no mem_ack_o; after release, fresh request serviced normally.
REQ-034 ARB_TIMEOUT_EN, TIMEOUT=8, ram_ack_i never -> after 8 ACC cycles err_o and mem_ack_o pulse, mem_rdata_o 0; without macro, still waiting after 100 cycles.
REQ-035 Back-to-back MEM requests held high through ack -> DONE gap of one cycle, second grant next IDLE cycle, no duplicate access.
